// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the core MEM stage and a debug/host master.
// The core has fixed priority, and a starvation counter forces one host grant after MAX_WAIT denials.
module dmem_port_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            core_req,
  input  logic            core_wren,
  input  logic [XLEN-1:0] core_address,
  input  logic [1:0]      core_mode,
  input  logic [XLEN-1:0] core_data,
  output logic            core_stall,
  output logic [XLEN-1:0] core_q,
  input  logic            host_valid,
  output logic            host_ready,
  input  logic            host_wren,
  input  logic [XLEN-1:0] host_address,
  input  logic [1:0]      host_mode,
  input  logic [XLEN-1:0] host_data,
  output logic            host_rsp_valid,
  output logic [XLEN-1:0] host_rsp_data,
  output logic [XLEN-1:0] mem_address,
  output logic [1:0]      mem_mode,
  output logic [XLEN-1:0] mem_data,
  output logic            mem_wren,
  input  logic [XLEN-1:0] mem_q
);

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_CORE,
    RSP_HOST_RD,
    RSP_HOST_WR
  } rsp_state_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  rsp_state_e state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       grant_host, grant_core;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RSP_NONE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    grant_host     = 1'b0;
    grant_core     = 1'b0;
    core_stall     = 1'b0;
    host_ready     = 1'b0;
    mem_address    = core_address;
    mem_mode       = core_mode;
    mem_data       = core_data;
    mem_wren       = 1'b0;
    wait_cnt_d     = wait_cnt_q;
    state_d        = RSP_NONE;
    core_q         = mem_q;
    host_rsp_valid = 1'b0;
    host_rsp_data  = '0;

    // Grants are suppressed while reset is held so nothing reaches memory mid-reset.
    grant_host = !reset && host_valid && (!core_req || wait_cnt_q == MAX_WAIT_C);
    grant_core = !reset && core_req && !grant_host;
    core_stall = core_req && grant_host;
    host_ready = grant_host;

    if (grant_host) begin
      mem_address = host_address;
      mem_mode    = host_mode;
      mem_data    = host_data;
    end
    mem_wren = (grant_host && host_wren) || (grant_core && core_wren);

    if (grant_host || !host_valid) begin
      wait_cnt_d = '0;
    end else if (core_req && wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // Memory read data lands one cycle later, so remember who owns it.
    if (grant_host) begin
      state_d = host_wren ? RSP_HOST_WR : RSP_HOST_RD;
    end else if (grant_core) begin
      state_d = RSP_CORE;
    end

    host_rsp_valid = !reset && (state_q == RSP_HOST_RD || state_q == RSP_HOST_WR);
    if (!reset && state_q == RSP_HOST_RD) begin
      host_rsp_data = mem_q;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model (denied-cycle count, owner of last access, word memory).
module tb_dmem_port_arbiter;

  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 8;
  localparam int K_NONE = 0, K_CRD = 1, K_CWR = 2, K_HRD = 3, K_HWR = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            core_req, core_wren, core_stall;
  logic [XLEN-1:0] core_address, core_data, core_q;
  logic [1:0]      core_mode;
  logic            host_valid, host_ready, host_wren, host_rsp_valid;
  logic [XLEN-1:0] host_address, host_data, host_rsp_data;
  logic [1:0]      host_mode;
  logic [XLEN-1:0] mem_address, mem_data, mem_q;
  logic [1:0]      mem_mode;
  logic            mem_wren;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int              m_wait;
  int              m_prev;
  logic [31:0]     m_rsp;
  logic [31:0]     model_mem [256];

  logic            exp_hg, exp_cg, exp_stall, exp_wren, exp_rsp_valid, exp_core_q_valid;
  logic [31:0]     exp_addr, exp_data, exp_rsp_data, exp_core_q;
  logic [1:0]      exp_mode;

  // Environment memory with registered inputs
  bit [31:0]       phys [256];
  bit              phys_vld [256];

  dmem_port_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_wren(core_wren), .core_address(core_address),
    .core_mode(core_mode), .core_data(core_data), .core_stall(core_stall), .core_q(core_q),
    .host_valid(host_valid), .host_ready(host_ready), .host_wren(host_wren),
    .host_address(host_address), .host_mode(host_mode), .host_data(host_data),
    .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data),
    .mem_address(mem_address), .mem_mode(mem_mode), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_val(input logic [7:0] i);
    return {8'hA5, i, ~i, 8'h5A};
  endfunction

  always @(posedge clock) begin
    if (mem_wren) begin
      phys[mem_address[9:2]]     <= mem_data;
      phys_vld[mem_address[9:2]] <= 1'b1;
    end
    mem_q <= phys_vld[mem_address[9:2]] ? phys[mem_address[9:2]] : init_val(mem_address[9:2]);
  end

  task automatic predict();
    #1;
    exp_hg           = !reset && host_valid && (!core_req || m_wait >= MAX_WAIT);
    exp_cg           = !reset && core_req && !exp_hg;
    exp_stall        = core_req && exp_hg;
    exp_wren         = (exp_hg && host_wren) || (exp_cg && core_wren);
    exp_addr         = exp_hg ? host_address : core_address;
    exp_data         = exp_hg ? host_data : core_data;
    exp_mode         = exp_hg ? host_mode : core_mode;
    exp_rsp_valid    = !reset && (m_prev == K_HRD || m_prev == K_HWR);
    exp_rsp_data     = (!reset && m_prev == K_HRD) ? m_rsp : 32'h0;
    exp_core_q_valid = (m_prev == K_CRD);
    exp_core_q       = m_rsp;
  endtask

  task automatic advance();
    @(posedge clock);
    if (reset) begin
      m_wait = 0;
      m_prev = K_NONE;
    end else begin
      if (exp_hg || !host_valid) m_wait = 0;
      else if (core_req && m_wait < MAX_WAIT) m_wait++;
      if (exp_hg) begin
        if (host_wren) begin
          model_mem[host_address[9:2]] = host_data;
          m_prev = K_HWR;
        end else begin
          m_rsp  = model_mem[host_address[9:2]];
          m_prev = K_HRD;
        end
      end else if (exp_cg) begin
        if (core_wren) begin
          model_mem[core_address[9:2]] = core_data;
          m_prev = K_CWR;
        end else begin
          m_rsp  = model_mem[core_address[9:2]];
          m_prev = K_CRD;
        end
      end else begin
        m_prev = K_NONE;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    core_req   = 1'b0; core_wren = 1'b0; core_address = '0; core_mode = 2'b10; core_data = '0;
    host_valid = 1'b0; host_wren = 1'b0; host_address = '0; host_mode = 2'b10; host_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    core_req = 1'b1; core_wren = 1'b1; host_valid = 1'b1; host_wren = 1'b1;
    predict();
    n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_ready got=%b exp=0", host_ready); end
    n_cmp++; if (core_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_stall got=%b exp=0", core_stall); end
    n_cmp++; if (mem_wren !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_wren got=%b exp=0", mem_wren); end
    n_cmp++; if (host_rsp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_rsp_valid got=%b exp=0", host_rsp_valid); end
    advance();
    idle_inputs();
    predict();
    n_cmp++; if (host_rsp_data !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_rsp_data got=%h exp=0", host_rsp_data); end
    advance();
    reset = 1'b0;
  endtask

  task automatic test_host_read();
    idle_inputs();
    host_valid = 1'b1; host_address = 32'h40; host_data = 32'h1234_5678;
    predict();
    n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL hrd_ready got=%b exp=1", host_ready); end
    n_cmp++; if (mem_address !== 32'h40) begin n_bad++; $display("[TB] FAIL hrd_addr got=%h exp=40", mem_address); end
    n_cmp++; if (mem_wren !== 1'b0) begin n_bad++; $display("[TB] FAIL hrd_wren got=%b exp=0", mem_wren); end
    advance();
    host_valid = 1'b0;
    predict();
    n_cmp++; if (host_rsp_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL hrd_rsp_valid got=%b exp=1", host_rsp_valid); end
    n_cmp++; if (host_rsp_data !== init_val(8'h10)) begin n_bad++; $display("[TB] FAIL hrd_rsp_data got=%h exp=%h", host_rsp_data, init_val(8'h10)); end
    n_cmp++; if (core_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL hrd_stall got=%b exp=0", core_stall); end
    advance();
    predict();
    n_cmp++; if (host_rsp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL hrd_rsp_once got=%b exp=0", host_rsp_valid); end
    advance();
  endtask

  task automatic test_core_priority();
    idle_inputs();
    core_req = 1'b1; core_address = 32'h80;
    host_valid = 1'b1; host_address = 32'h44;
    for (int i = 0; i < MAX_WAIT; i++) begin
      predict();
      n_cmp++; if (host_ready !== 1'b0 || core_stall !== 1'b0) begin
        n_bad++; $display("[TB] FAIL prio_wait cyc=%0d got ready=%b stall=%b exp 0/0", i, host_ready, core_stall);
      end
      advance();
    end
    predict();
    n_cmp++; if (host_ready !== 1'b1 || core_stall !== 1'b1) begin
      n_bad++; $display("[TB] FAIL prio_force got ready=%b stall=%b exp 1/1", host_ready, core_stall);
    end
    n_cmp++; if (mem_address !== 32'h44) begin n_bad++; $display("[TB] FAIL prio_addr got=%h exp=44", mem_address); end
    advance();
    host_valid = 1'b0;
    predict();
    n_cmp++; if (core_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL prio_release got=%b exp=0", core_stall); end
    n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_data !== exp_rsp_data) begin
      n_bad++; $display("[TB] FAIL prio_rsp got v=%b d=%h exp v=1 d=%h", host_rsp_valid, host_rsp_data, exp_rsp_data);
    end
    advance();
    core_req = 1'b0;
    predict();
    n_cmp++; if (core_q !== exp_core_q) begin n_bad++; $display("[TB] FAIL prio_core_q got=%h exp=%h", core_q, exp_core_q); end
    advance();
  endtask

  task automatic test_host_write();
    idle_inputs();
    host_valid = 1'b1; host_wren = 1'b1; host_address = 32'h10; host_data = 32'hDEADBEEF;
    predict();
    n_cmp++; if (host_ready !== 1'b1 || mem_wren !== 1'b1) begin
      n_bad++; $display("[TB] FAIL hwr_grant got ready=%b wren=%b exp 1/1", host_ready, mem_wren);
    end
    n_cmp++; if (mem_data !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL hwr_data got=%h exp=deadbeef", mem_data); end
    advance();
    idle_inputs();
    predict();
    n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_data !== 32'h0) begin
      n_bad++; $display("[TB] FAIL hwr_ack got v=%b d=%h exp v=1 d=0", host_rsp_valid, host_rsp_data);
    end
    n_cmp++; if (mem_wren !== 1'b0) begin n_bad++; $display("[TB] FAIL hwr_single got=%b exp=0", mem_wren); end
    advance();
    core_req = 1'b1; core_address = 32'h10;
    predict();
    n_cmp++; if (core_stall !== 1'b0 || mem_address !== 32'h10) begin
      n_bad++; $display("[TB] FAIL hwr_core_ld got stall=%b addr=%h exp 0/10", core_stall, mem_address);
    end
    advance();
    core_req = 1'b0;
    predict();
    n_cmp++; if (core_q !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL hwr_readback got=%h exp=deadbeef", core_q); end
    advance();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    core_req = 1'b1; core_address = 32'h20;
    predict();
    n_cmp++; if (core_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_core1 got=%b exp=0", core_stall); end
    advance();
    core_req = 1'b0; host_valid = 1'b1; host_address = 32'h24;
    predict();
    n_cmp++; if (core_q !== init_val(8'h08)) begin n_bad++; $display("[TB] FAIL b2b_core_q1 got=%h exp=%h", core_q, init_val(8'h08)); end
    n_cmp++; if (host_rsp_valid !== 1'b0 || host_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL b2b_host got v=%b ready=%b exp 0/1", host_rsp_valid, host_ready);
    end
    advance();
    host_valid = 1'b0; core_req = 1'b1; core_address = 32'h28;
    predict();
    n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_data !== init_val(8'h09)) begin
      n_bad++; $display("[TB] FAIL b2b_host_rsp got v=%b d=%h exp v=1 d=%h", host_rsp_valid, host_rsp_data, init_val(8'h09));
    end
    advance();
    core_req = 1'b0;
    predict();
    n_cmp++; if (core_q !== init_val(8'h0A) || host_rsp_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL b2b_core_q2 got q=%h v=%b exp q=%h v=0", core_q, host_rsp_valid, init_val(8'h0A));
    end
    advance();
  endtask

  task automatic test_host_drop();
    idle_inputs();
    core_req = 1'b1; core_address = 32'h30;
    host_valid = 1'b1; host_address = 32'h34;
    for (int i = 0; i < 5; i++) begin
      predict();
      n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL drop_pre cyc=%0d got=%b exp=0", i, host_ready); end
      advance();
    end
    host_valid = 1'b0;
    predict();
    advance();
    host_valid = 1'b1;
    for (int i = 0; i < MAX_WAIT; i++) begin
      predict();
      n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL drop_rewait cyc=%0d got=%b exp=0", i, host_ready); end
      advance();
    end
    predict();
    n_cmp++; if (host_ready !== 1'b1 || core_stall !== 1'b1) begin
      n_bad++; $display("[TB] FAIL drop_force got ready=%b stall=%b exp 1/1", host_ready, core_stall);
    end
    advance();
    idle_inputs();
    predict();
    advance();
  endtask

  task automatic test_reset_mid_op();
    idle_inputs();
    core_req = 1'b1; host_valid = 1'b1; host_address = 32'h50;
    for (int i = 0; i < 5; i++) begin
      predict();
      advance();
    end
    core_req = 1'b0;
    predict();
    n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_grant got=%b exp=1", host_ready); end
    advance();
    reset = 1'b1; host_valid = 1'b0;
    predict();
    n_cmp++; if (host_rsp_valid !== 1'b0 || mem_wren !== 1'b0) begin
      n_bad++; $display("[TB] FAIL rmid_drop got v=%b wren=%b exp 0/0", host_rsp_valid, mem_wren);
    end
    advance();
    reset = 1'b0;
    predict();
    n_cmp++; if (host_rsp_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_after got=%b exp=0", host_rsp_valid); end
    advance();
    // Build up denials, reset, then the host must wait a full MAX_WAIT again
    core_req = 1'b1; host_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      predict();
      advance();
    end
    reset = 1'b1;
    predict();
    advance();
    reset = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      predict();
      n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_cnt_clr cyc=%0d got=%b exp=0", i, host_ready); end
      advance();
    end
    predict();
    n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_force got=%b exp=1", host_ready); end
    advance();
    idle_inputs();
    predict();
    n_cmp++; if (host_rsp_valid !== 1'b1 || host_rsp_data !== exp_rsp_data) begin
      n_bad++; $display("[TB] FAIL rmid_resume got v=%b d=%h exp v=1 d=%h", host_rsp_valid, host_rsp_data, exp_rsp_data);
    end
    advance();
  endtask

  task automatic test_random();
    idle_inputs();
    predict();
    advance();
    for (int c = 0; c < 600; c++) begin
      if (!(host_valid && !exp_hg)) begin
        host_valid   = ($urandom_range(0, 1) == 1);
        host_wren    = ($urandom_range(0, 2) == 0);
        host_address = 32'($urandom_range(0, 15)) << 2;
        host_mode    = 2'($urandom_range(0, 3));
        host_data    = $urandom;
      end
      if (!(core_req && !exp_cg)) begin
        core_req     = ($urandom_range(0, 9) < 8);
        core_wren    = ($urandom_range(0, 2) == 0);
        core_address = 32'($urandom_range(0, 15)) << 2;
        core_mode    = 2'($urandom_range(0, 3));
        core_data    = $urandom;
      end
      reset = ($urandom_range(0, 63) == 0);
      predict();
      n_cmp++; if (host_ready !== exp_hg) begin n_bad++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp=%b", c, host_ready, exp_hg); end
      n_cmp++; if (core_stall !== exp_stall) begin n_bad++; $display("[TB] FAIL rnd_stall cyc=%0d got=%b exp=%b", c, core_stall, exp_stall); end
      n_cmp++; if (mem_wren !== exp_wren) begin n_bad++; $display("[TB] FAIL rnd_wren cyc=%0d got=%b exp=%b", c, mem_wren, exp_wren); end
      if (exp_hg || exp_cg) begin
        n_cmp++; if (mem_address !== exp_addr || mem_data !== exp_data || mem_mode !== exp_mode) begin
          n_bad++; $display("[TB] FAIL rnd_mux cyc=%0d got a=%h d=%h m=%0d exp a=%h d=%h m=%0d",
                            c, mem_address, mem_data, mem_mode, exp_addr, exp_data, exp_mode);
        end
      end
      n_cmp++; if (host_rsp_valid !== exp_rsp_valid) begin n_bad++; $display("[TB] FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", c, host_rsp_valid, exp_rsp_valid); end
      n_cmp++; if (host_rsp_data !== exp_rsp_data) begin n_bad++; $display("[TB] FAIL rnd_rsp_data cyc=%0d got=%h exp=%h", c, host_rsp_data, exp_rsp_data); end
      if (exp_core_q_valid) begin
        n_cmp++; if (core_q !== exp_core_q) begin n_bad++; $display("[TB] FAIL rnd_core_q cyc=%0d got=%h exp=%h", c, core_q, exp_core_q); end
      end
      advance();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    reset  = 1'b1;
    idle_inputs();
    m_wait = 0;
    m_prev = K_NONE;
    m_rsp  = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(8'(i));
    @(negedge clock);
    test_reset();
    test_host_read();
    test_core_priority();
    test_host_write();
    test_back_to_back();
    test_host_drop();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core MEM-stage access and an external debug/host master (loader, monitor).
- The core has fixed priority. A starvation counter forces a host grant after MAX_WAIT denied cycles, stalling the core for that cycle.
- The memory has registered inputs, so read data appears one cycle after the request. The arbiter tags each accepted access and routes the returned data to its owner.
- Sits between the pipeline's EX/MEM boundary and data_memory.

Parameters:
- XLEN, 32, data/address width
- MAX_WAIT, 8, host denied cycles before a forced grant (1..15)

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- core_req  in  1  core memory access valid this cycle (load or store)
- core_wren  in  1  core store
- core_address  in  XLEN  core byte address
- core_mode  in  2  core access size/sign mode
- core_data  in  XLEN  core store data
- core_stall  out  1  core access not accepted; core must hold request stable
- core_q  out  XLEN  read data for the core access accepted last cycle
- host_valid  in  1  host request valid
- host_ready  out  1  host request accepted this cycle
- host_wren  in  1  host write
- host_address  in  XLEN  host byte address
- host_mode  in  2  host access mode
- host_data  in  XLEN  host write data
- host_rsp_valid  out  1  host response pulse
- host_rsp_data  out  XLEN  host read data (0 for write acks)
- mem_address  out  XLEN  to data_memory address
- mem_mode  out  2  to data_memory mem_mode
- mem_data  out  XLEN  to data_memory data
- mem_wren  out  1  to data_memory wren
- mem_q  in  XLEN  from data_memory q (1-cycle latency)

Behaviour:
- Grant decision (combinational, same cycle):
  - grant_host = host_valid && (!core_req || wait_cnt == MAX_WAIT)
  - grant_core = core_req && !grant_host
- Outputs driven from the grant:
  - core_stall = core_req && grant_host
  - host_ready = grant_host
- Memory port mux:
  - grant_host: mem_* = host_*
  - otherwise: mem_* = core_*
  - mem_wren = (grant_host && host_wren) || (grant_core && core_wren); 0 when no grant.
- Starvation counter wait_cnt (4 bit, registered):
  - cleared when grant_host or !host_valid
  - else +1 when host_valid && core_req (denied), saturating at MAX_WAIT
- Response owner FSM, registered per cycle, states:
  - RSP_NONE: nothing accepted last cycle
  - RSP_CORE: core access accepted last cycle
  - RSP_HOST_RD: host read accepted last cycle
  - RSP_HOST_WR: host write accepted last cycle
- Next-state is set from this cycle's grant; there are no multi-cycle states, so back-to-back grants are allowed every cycle.
- Response outputs:
  - core_q = mem_q (passthrough; meaningful only when state was RSP_CORE)
  - host_rsp_valid = 1 in RSP_HOST_RD or RSP_HOST_WR
  - host_rsp_data = mem_q in RSP_HOST_RD, 0 in RSP_HOST_WR, 0 otherwise
  - host_rsp_valid and host_rsp_data are registered-state driven, never combinational from host_valid.
- Host handshake:
  - Request transfers when host_valid && host_ready.
  - Host must hold its fields stable while host_valid && !host_ready.
  - Host may issue a new request in the same cycle host_rsp_valid is high.
- Simultaneous requests:
  - Core wins unless wait_cnt == MAX_WAIT; then the host wins for exactly one cycle and the counter clears.
  - The core is guaranteed at least MAX_WAIT consecutive grants between forced host grants.
- Reset (synchronous, takes effect at the clock edge):
  - wait_cnt = 0, state = RSP_NONE
  - host_ready = 0, core_stall = 0, mem_wren = 0, host_rsp_valid = 0, host_rsp_data = 0
- Reset mid-transaction: a pending host response is dropped (no host_rsp_valid after reset). The host must reissue.
- Integration requirement: core_stall must freeze the core's EX and MEM pipeline registers as well as IF/ID. Otherwise a stalled store is lost.
- No address decoding: IO addresses are handled downstream in data_memory and are arbitrated identically.

Test Plan:
- Host read alone: host_valid=1, wren=0, addr=0x40, core_req=0 → host_ready=1 same cycle; next cycle host_rsp_valid=1, host_rsp_data=mem_q(0x40); core_stall=0 throughout.
- Core priority: core_req=1 every cycle, host_valid=1 held, MAX_WAIT=8 → host_ready=0 for 8 cycles; cycle 9 host_ready=1, core_stall=1, mem_address=host_address; cycle 10 core_stall=0, host_rsp_valid=1.
- Host write ack: host write 0xDEADBEEF to 0x10 with core idle → mem_wren=1, mem_data=0xDEADBEEF for one cycle; next cycle host_rsp_valid=1, host_rsp_data=0; a core load of 0x10 two cycles later returns core_q=0xDEADBEEF.
- Back-to-back alternation: core load, host read, core load on consecutive cycles → responses routed in order; host_rsp_valid high only in the cycle after the host grant.
- Host drop: host_valid asserted 5 cycles under core traffic, then deasserted → wait_cnt returns to 0; a new host request must wait a full 8 cycles again.
- Reset mid-op: host read granted, reset asserted on the next edge → host_rsp_valid=0, wait_cnt=0, mem_wren=0 after reset; normal operation resumes the cycle reset deasserts.
